ifid_queue: RTL and testbench
=============================

// Module: ifid_queue
// PURPOSE
//  Parametrised IF/ID boundary stage: a DEPTH-entry in-order queue of {pc, inst} pairs between fetch and decode.
//  Replaces the single-register IF/ID latch: adds valid/ready handshakes on both sides, a lock-vector stall,
//  a flush (clean) that empties the queue, and optional instruction byte-swap on entry.
//  Sits between the fetch stage (producer) and the decode stage (consumer) in the 5-stage core.
// PARAMETERS
//  ADDR_W    32  width of pc fields
//  INST_W    32  width of instruction fields (multiple of 8 when BSWAP=1)
//  DEPTH     2   queue entries; power of 2, >= 2
//  LOCK_W    5   width of the pipeline lock vector
//  LOCK_BIT  1   index of the lock bit that stalls this stage
//  BSWAP     0   1: reverse byte order of if_inst when it is written into the queue
// PORTS
//  clk           in   1                     clock; all state updates on rising edge
//  rst           in   1                     synchronous reset, active-low (rst==0 resets on the clock edge)
//  if_valid_i    in   1                     fetch presents a valid {if_pc, if_inst}
//  if_ready_o    out  1                     queue can accept an entry this cycle
//  if_pc         in   ADDR_W                fetched pc
//  if_inst       in   INST_W                fetched instruction
//  lock          in   LOCK_W                pipeline lock vector; lock[LOCK_BIT]=1 stalls dequeue
//  IFID_clean_i  in   1                     flush: discard all queued entries
//  id_valid_o    out  1                     head entry valid toward decode
//  id_ready_i    in   1                     decode accepts head entry
//  id_pc         out  ADDR_W                head pc; all-zero when queue empty
//  id_inst       out  INST_W                head inst; all-zero (bubble) when queue empty
//  count_o       out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus count register.
//  - Reset (rst==0 at edge): wr_ptr=rd_ptr=count=0; outputs: if_ready_o=1, id_valid_o=0, id_pc=0, id_inst=0,
//    count_o=0. Storage contents are don't-care after reset. Reset overrides every other input.
//  - push = if_valid_i & if_ready_o; pop = id_valid_o & id_ready_i & ~lock[LOCK_BIT].
//  - if_ready_o = (count != DEPTH); id_valid_o = (count != 0). Both derive from registered state only.
//  - Latency: an entry pushed at edge N is presented on id_* from edge N onward (visible in cycle N+1);
//    no combinational fall-through from if_* to id_*.
//  - id_pc/id_inst = entry at rd_ptr when count!=0, else zero words.
//  - BSWAP=1: stored inst = byte-reversed if_inst (byte 0 <-> byte INST_W/8-1); pc never modified.
//  - Simultaneous push & pop (only possible when 0<count<DEPTH): both occur, count unchanged, pointers advance.
//  - Full: if_ready_o=0; if_valid_i ignored, no overwrite. Empty: no pop, outputs zero.
//  - lock[LOCK_BIT]=1: head held stable (id_* unchanged), push still allowed while not full.
//    Other lock bits have no effect.
//  - Flush (IFID_clean_i=1, rst=1): next state wr_ptr=rd_ptr=count=0; any same-cycle push or pop is discarded;
//    flush wins over lock. Next cycle: id_valid_o=0, id_* zero, if_ready_o=1.
//  - Priority: reset > flush > push/pop.
//  - Assertions (sim only): count<=DEPTH; no push when count==DEPTH; no pop when count==0.
// TESTING
//  1. Hold rst=0 2 cycles, random inputs -> id_valid_o=0, id_pc=id_inst=0, if_ready_o=1, count_o=0.
//  2. Push pc=0x0000_1000 inst=0x0000_0013, id_ready_i=0 -> next cycle id_valid_o=1, id_pc=0x1000,
//     id_inst=0x13, count_o=1.
//  3. DEPTH=2: push 3 back-to-back (0x1000,0x1004,0x1008), id_ready_i=0 -> count_o=2, if_ready_o=0,
//     0x1008 not accepted; pop twice -> 0x1000 then 0x1004, then empty.
//  4. count=1, push 0x2004 with pop same cycle -> count_o stays 1, id_pc=0x2004 next cycle;
//     repeat 5 times to exercise pointer wrap.
//  5. count=2, lock[1]=1, id_ready_i=1 for 3 cycles -> id_pc held, count_o=2; lock[0]=1 alone -> pop proceeds.
//  6. count=2, IFID_clean_i=1 with if_valid_i=1 -> next cycle count_o=0, id_inst=0;
//     BSWAP=1 push inst=0x1122_3344 -> id_inst=0x4433_2211.

Source files
------------

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - IF/ID boundary queue of {pc, inst} pairs with handshakes, lock stall and flush
module ifid_queue #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int DEPTH    = 2,
  parameter int LOCK_W   = 5,
  parameter int LOCK_BIT = 1,
  parameter int BSWAP    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [LOCK_W-1:0]          lock,
  input  logic                       IFID_clean_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic             stall;
  logic [INST_W-1:0] inst_wr;
  logic             lock_unused;

  // Only one bit of the shared lock vector concerns this stage.
  assign stall       = lock[LOCK_BIT];
  assign lock_unused = ^lock;

  // Handshake state comes from registered occupancy only, so nothing falls through.
  assign if_ready_o = (count_q != CNT_FULL);
  assign id_valid_o = (count_q != '0);
  assign count_o    = count_q;

  assign push = if_valid_i & if_ready_o;
  assign pop  = id_valid_o & id_ready_i & ~stall;

  // Head entry toward decode, zero bubble when empty.
  assign id_pc   = id_valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign id_inst = id_valid_o ? inst_mem[rd_ptr_q] : '0;

  generate
    if (BSWAP != 0) begin : g_bswap
      // Reverse byte order of the incoming instruction before it is stored.
      always_comb begin
        inst_wr = '0;
        for (int b = 0; b < INST_W/8; b++) begin
          inst_wr[8*b +: 8] = if_inst[INST_W-8-8*b +: 8];
        end
      end
    end else begin : g_pass
      assign inst_wr = if_inst;
    end
  endgenerate

  // Pointer/occupancy next state: flush empties the queue and discards any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (IFID_clean_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers; reset overrides flush and traffic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge clk) begin
    if (rst && push && !IFID_clean_i) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      inst_mem[wr_ptr_q] <= inst_wr;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && count_q == CNT_FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && count_q == '0));

endmodule

// File: tb/tb_ifid_queue.sv
// tb/tb_ifid_queue.sv - self-checking bench for ifid_queue
module tb_ifid_queue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  lock;
  logic        clean;
  logic        id_ready;

  logic        a_if_ready, a_id_valid;
  logic [31:0] a_id_pc, a_id_inst;
  logic [1:0]  a_count;
  logic        b_if_ready, b_id_valid;
  logic [31:0] b_id_pc, b_id_inst;
  logic [1:0]  b_count;

  ifid_queue #(.DEPTH(DEPTH), .BSWAP(0)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(a_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .lock(lock), .IFID_clean_i(clean),
    .id_valid_o(a_id_valid), .id_ready_i(id_ready), .id_pc(a_id_pc),
    .id_inst(a_id_inst), .count_o(a_count)
  );

  ifid_queue #(.DEPTH(DEPTH), .BSWAP(1)) dut_swap (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(b_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .lock(lock), .IFID_clean_i(clean),
    .id_valid_o(b_id_valid), .id_ready_i(id_ready), .id_pc(b_id_pc),
    .id_inst(b_id_inst), .count_o(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  lk;
    logic        cl;
    logic        rdy;
    int          cnt;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  ent_t mq[$];
  vec_t vecs[$];
  int   nerr = 0;
  int   nchk = 0;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [4:0] lk, input logic cl, input logic rdy,
                              input int cnt, input logic [31:0] epc, input logic [31:0] einst);
    vec_t r;
    r.v = v; r.pc = pc; r.inst = inst; r.lk = lk; r.cl = cl; r.rdy = rdy;
    r.cnt = cnt; r.epc = epc; r.einst = einst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the queue model.
  task automatic check_model();
    logic [31:0] epc, einst;
    int sz;
    sz    = mq.size();
    epc   = (sz != 0) ? mq[0].pc   : 32'h0;
    einst = (sz != 0) ? mq[0].inst : 32'h0;
    chk("count",      64'(a_count),    64'(sz));
    chk("id_valid",   64'(a_id_valid), 64'(sz != 0));
    chk("if_ready",   64'(a_if_ready), 64'(sz < DEPTH));
    chk("id_pc",      64'(a_id_pc),    64'(epc));
    chk("id_inst",    64'(a_id_inst),  64'(einst));
    chk("swap_count", 64'(b_count),    64'(sz));
    chk("swap_pc",    64'(b_id_pc),    64'(epc));
    chk("swap_inst",  64'(b_id_inst),  64'(bswap(einst)));
  endtask

  // One clock with the inputs already driven; the model follows the queue rules directly.
  task automatic step();
    bit mpush, mpop;
    mpush = if_valid && (mq.size() < DEPTH);
    mpop  = (mq.size() > 0) && id_ready && !lock[1];
    @(posedge clk);
    if (!rst || clean) begin
      mq.delete();
    end else begin
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back({if_pc, if_inst});
    end
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_pc = '0; if_inst = '0; lock = '0; clean = 0; id_ready = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();

    // Reset held two cycles with random traffic on every input.
    for (int i = 0; i < 2; i++) begin
      if_valid = 1'($urandom); if_pc = $urandom; if_inst = $urandom;
      lock = 5'($urandom); clean = 1'($urandom); id_ready = 1'($urandom);
      step();
    end
    chk("rst_valid", 64'(a_id_valid), 64'(0));
    chk("rst_ready", 64'(a_if_ready), 64'(1));
    chk("rst_count", 64'(a_count),    64'(0));
    chk("rst_pc",    64'(a_id_pc),    64'(0));
    chk("rst_inst",  64'(a_id_inst),  64'(0));

    rst = 1;
    idle_inputs();
    step();

    // Directed table: fill, overflow, drain, wrap, lock, flush, byte swap.
    vecs.push_back(mk(1, 32'h1000, 32'h13,       5'b00000, 0, 0, 1, 32'h1000, 32'h13));
    vecs.push_back(mk(1, 32'h1004, 32'h93,       5'b00000, 0, 0, 2, 32'h1000, 32'h13));
    vecs.push_back(mk(1, 32'h1008, 32'h113,      5'b00000, 0, 0, 2, 32'h1000, 32'h13));
    vecs.push_back(mk(0, 32'h0,    32'h0,        5'b00000, 0, 1, 1, 32'h1004, 32'h93));
    vecs.push_back(mk(0, 32'h0,    32'h0,        5'b00000, 0, 1, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 32'h2000, 32'h2000,     5'b00000, 0, 0, 1, 32'h2000, 32'h2000));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(1, 32'h2000 + 4*k, 32'h2000 + 4*k, 5'b00000, 0, 1, 1,
                        32'h2000 + 4*k, 32'h2000 + 4*k));
    vecs.push_back(mk(1, 32'h3000, 32'h3000,     5'b00000, 0, 0, 2, 32'h2014, 32'h2014));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 32'h3abc, 32'h3abc,   5'b00010, 0, 1, 2, 32'h2014, 32'h2014));
    vecs.push_back(mk(0, 32'h0,    32'h0,        5'b00001, 0, 1, 1, 32'h3000, 32'h3000));
    vecs.push_back(mk(1, 32'h3004, 32'h3004,     5'b00000, 0, 0, 2, 32'h3000, 32'h3000));
    vecs.push_back(mk(1, 32'h3008, 32'h3008,     5'b00010, 1, 1, 0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 32'h4000, 32'h11223344, 5'b00000, 0, 0, 1, 32'h4000, 32'h11223344));

    foreach (vecs[i]) begin
      if_valid = vecs[i].v; if_pc = vecs[i].pc; if_inst = vecs[i].inst;
      lock = vecs[i].lk; clean = vecs[i].cl; id_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_count", i), 64'(a_count),    64'(vecs[i].cnt));
      chk($sformatf("vec%0d_valid", i), 64'(a_id_valid), 64'(vecs[i].cnt != 0));
      chk($sformatf("vec%0d_ready", i), 64'(a_if_ready), 64'(vecs[i].cnt < DEPTH));
      chk($sformatf("vec%0d_pc", i),    64'(a_id_pc),    64'(vecs[i].epc));
      chk($sformatf("vec%0d_inst", i),  64'(a_id_inst),  64'(vecs[i].einst));
    end
    chk("bswap_example", 64'(b_id_inst), 64'(32'h44332211));

    // Randomized traffic including occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      if_valid = 1'($urandom);
      if_pc    = $urandom;
      if_inst  = $urandom;
      lock     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      clean    = ($urandom_range(0, 15) == 0);
      id_ready = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 63) != 0);
      step();
    end

    rst = 1;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
